// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves branches/jumps, checks load/store alignment and
// holds up to two entries in a skid buffer so out_ready never reaches in_ready combinationally.
module ex_mem_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic            in_alu_zero,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_target,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic            in_is_branch,
  input  logic            in_is_jump,
  input  logic [2:0]      in_funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [2:0]      out_funct3,
  output logic            out_misaligned,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            rd_we;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
    logic            misaligned;
  } entry_t;

  entry_t          main_q, skid_q, entry_d;
  logic            main_valid_q, skid_valid_q;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            br_cond, taken, misaligned, accept, pop;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & ~skid_valid_q & ~flush;
  assign pop      = main_valid_q & out_ready;

  // SLT/SLTU result bit 0 carries the compare outcome for the ordered branches.
  always_comb begin
    br_cond = 1'b0;
    case (in_funct3)
      3'b000:         br_cond = in_alu_zero;
      3'b001:         br_cond = ~in_alu_zero;
      3'b100, 3'b110: br_cond = in_alu_result[0];
      3'b101, 3'b111: br_cond = ~in_alu_result[0];
      default:        br_cond = 1'b0;
    endcase
    taken = in_is_jump | (in_is_branch & br_cond);
  end

  always_comb begin
    misaligned = 1'b0;
    if (in_mem_read | in_mem_write) begin
      case (in_funct3[1:0])
        2'b10:   misaligned = |in_alu_result[1:0];
        2'b01:   misaligned = in_alu_result[0];
        default: misaligned = 1'b0;
      endcase
    end
  end

  always_comb begin
    entry_d            = '0;
    entry_d.result     = in_is_jump ? in_pc_plus4 : in_alu_result;
    entry_d.store_data = in_store_data;
    entry_d.rd         = in_rd;
    entry_d.rd_we      = in_rd_we & ~(in_is_branch & ~in_is_jump) & ~misaligned;
    entry_d.mem_read   = in_mem_read & ~misaligned;
    entry_d.mem_write  = in_mem_write & ~misaligned;
    entry_d.funct3     = in_funct3;
    entry_d.misaligned = misaligned;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q        <= '0;
      skid_q        <= '0;
      main_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= accept & taken;
      if (accept & taken) begin
        redirect_pc_q <= in_target & ~{{(XLEN-1){1'b0}}, 1'b1};
      end
      if (flush) begin
        main_valid_q <= 1'b0;
        skid_valid_q <= 1'b0;
      end else if (!main_valid_q) begin
        if (accept) begin
          main_q       <= entry_d;
          main_valid_q <= 1'b1;
        end
      end else if (pop && skid_valid_q) begin
        main_q       <= skid_q;
        skid_valid_q <= 1'b0;
      end else if (pop) begin
        if (accept) begin
          main_q <= entry_d;
        end else begin
          main_valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_q       <= entry_d;
        skid_valid_q <= 1'b1;
      end
    end
  end

  assign out_valid      = main_valid_q;
  assign out_result     = main_q.result;
  assign out_store_data = main_q.store_data;
  assign out_rd         = main_q.rd;
  assign out_rd_we      = main_q.rd_we;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;
  assign out_funct3     = main_q.funct3;
  assign out_misaligned = main_q.misaligned;
  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;

endmodule
